// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU driven by the 4-bit ALUCtrl code.
// Single-cycle ops complete one cycle after acceptance. MUL runs as an
// iterative shift-add over WIDTH cycles, and ready_o is held low while it
// is in flight.
// Optional feature macro: MUL_EARLY_TERM_EN. When defined, a multiply
// finishes as soon as the remaining multiplier bits are all zero.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SRAI = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1111;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] alu_res;
    logic [SHW:0]     cnt;
    logic             accept;
    logic             start_mul;
    logic             mul_done;

    assign accept    = valid_i && ready_o;
    assign start_mul = accept && (ctrl_i == OP_MUL);

    // The partial-product add is skipped when the multiplier LSB is zero, so
    // an early-terminated multiply (mplier == 0) also writes acc unchanged.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MUL_EARLY_TERM_EN
    assign mul_done = (cnt == (SHW+1)'(1)) || (mplier == '0);
`else
    assign mul_done = (cnt == (SHW+1)'(1));
`endif

    // Single-cycle operation results, computed directly from the request inputs
    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            OP_AND:  alu_res = data1_i & data2_i;
            OP_XOR:  alu_res = data1_i ^ data2_i;
            OP_SLL:  alu_res = data1_i << data2_i[SHW-1:0];
            OP_ADD:  alu_res = data1_i + data2_i;
            OP_SUB:  alu_res = data1_i - data2_i;
            OP_ADDI: alu_res = data1_i + data2_i;
            OP_SRAI: alu_res = $signed(data1_i) >>> data2_i[SHW-1:0];
            OP_OR:   alu_res = data1_i | data2_i;
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: enter MUL_BUSY on an accepted MUL, leave on completion
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_mul) state_nxt = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Handshake output: only idle cycles can take a new request
    always_comb begin
        ready_o = (state == IDLE);
    end

    // Datapath: result register, completion pulse and shift-add multiplier
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        mcand  <= data1_i;
                        mplier <= data2_i;
                        acc    <= '0;
                        cnt    <= (SHW+1)'(WIDTH);
                    end else if (accept) begin
                        result_o <= alu_res;
                        zero_o   <= (alu_res == '0);
                        valid_o  <= 1'b1;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (mul_done) begin
                        result_o <= acc_sum;
                        zero_o   <= (acc_sum == '0);
                        valid_o  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (WIDTH=32).
// Expected results are queued as each request is driven. A negedge monitor
// pops and compares them whenever valid_o is seen. Scenario tasks also check
// latency and handshake timing. MUL latency expectations follow
// MUL_EARLY_TERM_EN, so the same bench serves both builds.
module tb_alu_multicycle;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk_i;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    alu_multicycle #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ctrl_i   (ctrl_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .valid_o  (valid_o),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    // Free-running 10 ns clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor: every valid_o must match the oldest queued expectation
    always @(negedge clk_i) begin
        if (rst_i && valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_valid: valid_o=1 with no pending op, result_o=%h", result_o);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                checks++;
                if (result_o !== e) begin
                    errors++;
                    $display("[TB] FAIL result: got %h expected %h", result_o, e);
                end
                checks++;
                if (zero_o !== (e == '0)) begin
                    errors++;
                    $display("[TB] FAIL zero: got %b expected %b (result %h)", zero_o, (e == '0), e);
                end
            end
        end
    end

    // Busy-cycle count for a multiply with multiplier b
    function automatic int mul_busy_cycles(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int msb;
        if (b == '0) return 1;
        msb = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) msb = i;
        return (msb + 2 > WIDTH) ? WIDTH : msb + 2;
`else
        return (b == b) ? WIDTH : WIDTH;
`endif
    endfunction

    task automatic test_reset();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        ctrl_i  = 4'b0;
        data1_i = '0;
        data2_i = '0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_o); end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
        checks++;
        if (result_o !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result_o); end
        checks++;
        if (zero_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero: got %b expected 0", zero_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_add_sub();
        valid_i = 1'b1; ctrl_i = 4'b0011; data1_i = 32'h7FFF_FFFF; data2_i = 32'h1;
        exp_q.push_back(32'h8000_0000);
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL add_latency: valid_o got %b expected 1", valid_o); end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL add_pulse: valid_o got %b expected 0", valid_o); end
        checks++;
        if (result_o !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_hold: got %h expected 80000000", result_o); end
        valid_i = 1'b1; ctrl_i = 4'b0100; data1_i = 32'd5; data2_i = 32'd5;
        exp_q.push_back(32'h0);
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if (zero_o !== 1'b1 || valid_o !== 1'b1) begin
            errors++; $display("[TB] FAIL sub_zero: zero_o=%b valid_o=%b expected 1/1", zero_o, valid_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        logic [3:0]       ops [5];
        logic [WIDTH-1:0] as  [5];
        logic [WIDTH-1:0] bs  [5];
        logic [WIDTH-1:0] es  [5];
        ops[0] = 4'b0001; as[0] = 32'hF0F0_F0F0; bs[0] = 32'hFFFF_0000; es[0] = 32'h0F0F_F0F0;
        ops[1] = 4'b0010; as[1] = 32'h1;         bs[1] = 32'd33;        es[1] = 32'h2;
        ops[2] = 4'b0111; as[2] = 32'h8000_0000; bs[2] = 32'd4;         es[2] = 32'hF800_0000;
        ops[3] = 4'b1111; as[3] = 32'h1234_0000; bs[3] = 32'h0000_5678; es[3] = 32'h1234_5678;
        ops[4] = 4'b1010; as[4] = 32'hDEAD_BEEF; bs[4] = 32'h1;         es[4] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; ctrl_i = ops[i]; data1_i = as[i]; data2_i = bs[i];
            exp_q.push_back(es[i]);
            @(negedge clk_i);
            checks++;
            if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, valid_o); end
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: valid_o got %b expected 0", valid_o); end
    endtask

    task automatic test_mul_case(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit pulse_busy);
        int exp_busy;
        int busy;
        int done_t;
        logic ready_at_done;
        logic [63:0] prod;
        prod     = 64'(a) * 64'(b);
        exp_busy = mul_busy_cycles(b);
        busy     = 0;
        done_t   = 0;
        ready_at_done = 1'b0;
        valid_i = 1'b1; ctrl_i = 4'b0101; data1_i = a; data2_i = b;
        exp_q.push_back(prod[WIDTH-1:0]);
        @(negedge clk_i);
        valid_i = 1'b0;
        for (int t = 1; t <= WIDTH + 8; t++) begin
            if (valid_o) begin
                done_t = t;
                ready_at_done = ready_o;
                break;
            end
            if (!ready_o) busy++;
            if (pulse_busy && (t == 3 || t == 10) && !ready_o) begin
                valid_i = 1'b1; ctrl_i = 4'b0011; data1_i = 32'h11; data2_i = 32'h22;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        checks++;
        if (done_t == 0) begin
            errors++; $display("[TB] FAIL mul_timeout: no valid_o for %h*%h", a, b);
        end else if (done_t != exp_busy + 1) begin
            errors++; $display("[TB] FAIL mul_latency: valid_o at N+%0d expected N+%0d", done_t, exp_busy + 1);
        end
        checks++;
        if (busy != exp_busy) begin errors++; $display("[TB] FAIL mul_busy: ready_o low %0d cycles expected %0d", busy, exp_busy); end
        checks++;
        if (ready_at_done !== 1'b1) begin errors++; $display("[TB] FAIL mul_ready: got %b expected 1 at completion", ready_at_done); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_mul();
        valid_i = 1'b1; ctrl_i = 4'b0101; data1_i = 32'h1234_5678; data2_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_ctrl: ready_o=%b valid_o=%b expected 1/0", ready_o, valid_o);
        end
        checks++;
        if (result_o !== '0 || zero_o !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_data: result_o=%h zero_o=%b expected 0/0", result_o, zero_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (WIDTH + 4) @(negedge clk_i);
        valid_i = 1'b1; ctrl_i = 4'b0011; data1_i = 32'd2; data2_i = 32'd2;
        exp_q.push_back(32'd4);
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'd4) begin
            errors++; $display("[TB] FAIL post_reset_add: valid_o=%b result_o=%h expected 1/4", valid_o, result_o);
        end
        @(negedge clk_i);
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_mul_case(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        test_mul_case(32'd7, 32'd0, 1'b0);
        test_mul_case(32'd6, 32'd3, 1'b0);
        test_mul_case(32'd2, 32'h8000_0000, 1'b0);
        test_mul_case(32'h0001_2345, 32'h0000_0ABC, 1'b0);
        test_reset_mid_mul();
        repeat (3) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("[TB] FAIL pending: %0d results never produced, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
